jk_drive_encoder: RTL and testbench

Transmit-side companion for a bank of JK latches. It accepts a target state word over a valid/ready handshake and compares it against a shadow copy of the bank's current state. It then produces the minimal per-bit J/K excitation pattern and holds it for a programmable number of cycles. When the drive window ends, it updates the shadow, pulses `done` and counts the bit transitions it commanded.

---
 rtl/jk_drive_pkg.sv | 17 +
 rtl/jk_bit_encode.sv | 28 ++
 rtl/jk_drive_encoder.sv | 138 +++++++++++++
 tb/tb_jk_drive_encoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/jk_drive_pkg.sv
// Shared types and {j,k} excitation codes for the JK drive encoder.
package jk_drive_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENCODE  = 2'd1,
        DRIVE   = 2'd2,
        RELEASE = 2'd3
    } jk_state_e;

    // Codes are packed as {j,k}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_bit_encode.sv
// Per-bit JK excitation from current and target latch state.
// Macro JK_DRIVE_TOGGLE_EN: encode every change as toggle instead of set/reset.
module jk_bit_encode
    import jk_drive_pkg::*;
(
    input  logic cur,
    input  logic tgt,
    output logic j,
    output logic k
);

    logic [1:0] code;

    always_comb begin
        code = JK_HOLD;
        if (cur != tgt) begin
`ifdef JK_DRIVE_TOGGLE_EN
            code = JK_TOGGLE;
`else
            code = tgt ? JK_SET : JK_RESET;
`endif
        end
    end

    assign j = code[1];
    assign k = code[0];

endmodule

// File: rtl/jk_drive_encoder.sv
// Drives minimal J/K excitation toward a target word, tracks shadow state and change count.
// Macro JK_DRIVE_TOGGLE_EN (in jk_bit_encode) selects toggle encoding.
module jk_drive_encoder
    import jk_drive_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             drv_active,
    output logic             done,
    output logic [WIDTH-1:0] shadow_q,
    output logic [7:0]       change_cnt
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    jk_state_e        state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic             drv_q, drv_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shadow_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CW-1:0]    hold_q, hold_d;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] enc_j, enc_k;
    logic [31:0]      pop;
    logic [31:0]      sum;

    for (genvar b = 0; b < WIDTH; b++) begin : g_enc
        jk_bit_encode u_enc (
            .cur (shadow_q[b]),
            .tgt (tgt_q[b]),
            .j   (enc_j[b]),
            .k   (enc_k[b])
        );
    end

    assign diff = shadow_q ^ tgt_q;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop = pop + {31'b0, diff[i]};
        end
        sum = {24'b0, cnt_q} + pop;
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        j_d      = '0;
        k_d      = '0;
        drv_d    = 1'b0;
        done_d   = 1'b0;
        hold_d   = hold_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                if (diff != '0) begin
                    j_d     = enc_j;
                    k_d     = enc_k;
                    drv_d   = 1'b1;
                    hold_d  = CW'(HOLD_CYCLES - 1);
                    state_d = DRIVE;
                end else begin
                    done_d  = 1'b1;
                    state_d = RELEASE;
                end
            end
            DRIVE: begin
                if (hold_q == '0) begin
                    done_d  = 1'b1;
                    state_d = RELEASE;
                end else begin
                    hold_d = hold_q - 1'b1;
                    j_d    = j_q;
                    k_d    = k_q;
                    drv_d  = 1'b1;
                end
            end
            RELEASE: begin
                // Shadow has not moved yet, so diff still describes this update
                shadow_d = tgt_q;
                cnt_d    = (sum > 32'd255) ? 8'hFF : sum[7:0];
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tgt_q    <= '0;
            j_q      <= '0;
            k_q      <= '0;
            drv_q    <= 1'b0;
            done_q   <= 1'b0;
            hold_q   <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            j_q      <= j_d;
            k_q      <= k_d;
            drv_q    <= drv_d;
            done_q   <= done_d;
            hold_q   <= hold_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tgt_ready  = (state_q == IDLE) && !rst;
    assign j          = j_q;
    assign k          = k_q;
    assign drv_active = drv_q;
    assign done       = done_q;
    assign change_cnt = cnt_q;

endmodule

// File: tb/tb_jk_drive_encoder.sv
// Directed self-checking bench for jk_drive_encoder (WIDTH=4, HOLD_CYCLES=2).
module tb_jk_drive_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] tgt_data = '0;
    logic [3:0] j, k;
    logic       drv_active;
    logic       done;
    logic [3:0] shadow_q;
    logic [7:0] change_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    jk_drive_encoder #(.WIDTH(4), .HOLD_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .tgt_data   (tgt_data),
        .j          (j),
        .k          (k),
        .drv_active (drv_active),
        .done       (done),
        .shadow_q   (shadow_q),
        .change_cnt (change_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_j"},   32'(j), 32'h0);
        check({tag, "_k"},   32'(k), 32'h0);
        check({tag, "_drv"}, 32'(drv_active), 32'h0);
    endtask

    // Full update with bounded waits; checks shadow and count after completion
    task automatic do_update(input logic [3:0] data, input logic [7:0] exp_cnt);
        int unsigned n;
        n = 0;
        while (!tgt_ready && n < 20) begin tick(); n++; end
        check("upd_ready_wait", 32'(tgt_ready), 32'h1);
        tgt_valid = 1'b1;
        tgt_data  = data;
        tick();
        tgt_valid = 1'b0;
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        check("upd_done_wait", 32'(done), 32'h1);
        tick();
        check("upd_shadow", 32'(shadow_q), 32'(data));
        check("upd_cnt", 32'(change_cnt), 32'(exp_cnt));
    endtask

    logic [3:0] exp_j, exp_k;
    int unsigned model_cnt;

    initial begin
        // Reset held from time 0
        tick();
        tick();
        check("rst_ready", 32'(tgt_ready), 32'h0);
        check_idle_outs("rst");
        check("rst_done", 32'(done), 32'h0);
        check("rst_shadow", 32'(shadow_q), 32'h0);
        check("rst_cnt", 32'(change_cnt), 32'h0);
        #3 rst = 1'b0;
        tick();
        check("rst_rel_ready", 32'(tgt_ready), 32'h1);

        // Update 1: 0000 -> 1010
`ifdef JK_DRIVE_TOGGLE_EN
        exp_j = 4'b1010; exp_k = 4'b1010;
`else
        exp_j = 4'b1010; exp_k = 4'b0000;
`endif
        tgt_valid = 1'b1;
        tgt_data  = 4'b1010;
        tick();                                 // E0 accept
        tgt_valid = 1'b0;
        check("u1_enc_ready", 32'(tgt_ready), 32'h0);
        check_idle_outs("u1_enc");
        tick();                                 // E1
        check("u1_d1_j", 32'(j), 32'(exp_j));
        check("u1_d1_k", 32'(k), 32'(exp_k));
        check("u1_d1_drv", 32'(drv_active), 32'h1);
        tick();                                 // E2
        check("u1_d2_j", 32'(j), 32'(exp_j));
        check("u1_d2_k", 32'(k), 32'(exp_k));
        check("u1_d2_done", 32'(done), 32'h0);
        tick();                                 // E3 release
        check_idle_outs("u1_rel");
        check("u1_rel_done", 32'(done), 32'h1);
        check("u1_rel_shadow", 32'(shadow_q), 32'h0);
        tick();                                 // E4 idle
        check("u1_end_done", 32'(done), 32'h0);
        check("u1_end_ready", 32'(tgt_ready), 32'h1);
        check("u1_end_shadow", 32'(shadow_q), 32'hA);
        check("u1_end_cnt", 32'(change_cnt), 32'd2);

        // Update 2: 1010 -> 0110, with a stray valid during DRIVE
`ifdef JK_DRIVE_TOGGLE_EN
        exp_j = 4'b1100; exp_k = 4'b1100;
`else
        exp_j = 4'b0100; exp_k = 4'b1000;
`endif
        tgt_valid = 1'b1;
        tgt_data  = 4'b0110;
        tick();
        tgt_valid = 1'b0;
        tick();
        check("u2_d1_j", 32'(j), 32'(exp_j));
        check("u2_d1_k", 32'(k), 32'(exp_k));
        tgt_valid = 1'b1;
        tgt_data  = 4'b1111;
        tick();
        check("u2_d2_j", 32'(j), 32'(exp_j));
        check("u2_d2_k", 32'(k), 32'(exp_k));
        check("u2_d2_drv", 32'(drv_active), 32'h1);
        tgt_valid = 1'b0;
        tick();
        check("u2_rel_done", 32'(done), 32'h1);
        tick();
        check("u2_end_shadow", 32'(shadow_q), 32'h6);
        check("u2_end_cnt", 32'(change_cnt), 32'd4);
        check("u2_end_ready", 32'(tgt_ready), 32'h1);
        tick();
        check("u2_stray_ignored", 32'(tgt_ready), 32'h1);

        // Update 3: no-change update
        tgt_valid = 1'b1;
        tgt_data  = 4'b0110;
        tick();
        tgt_valid = 1'b0;
        check_idle_outs("u3_enc");
        tick();
        check_idle_outs("u3_rel");
        check("u3_rel_done", 32'(done), 32'h1);
        tick();
        check("u3_end_done", 32'(done), 32'h0);
        check("u3_end_ready", 32'(tgt_ready), 32'h1);
        check("u3_end_cnt", 32'(change_cnt), 32'd4);
        check("u3_end_shadow", 32'(shadow_q), 32'h6);

        // Async reset during second DRIVE cycle
        tgt_valid = 1'b1;
        tgt_data  = 4'b1001;
        tick();
        tgt_valid = 1'b0;
        tick();
        tick();
        check("u4_pre_drv", 32'(drv_active), 32'h1);
        #2 rst = 1'b1;
        #1;
        check_idle_outs("u4_async");
        check("u4_async_shadow", 32'(shadow_q), 32'h0);
        check("u4_async_cnt", 32'(change_cnt), 32'h0);
        check("u4_async_ready", 32'(tgt_ready), 32'h0);
        #3 rst = 1'b0;
        tick();
        check("u4_rel_ready", 32'(tgt_ready), 32'h1);
        check("u4_rel_done", 32'(done), 32'h0);

        // Saturation: alternate 1111/0000 for 64 updates, then two more
        model_cnt = 0;
        for (int i = 0; i < 66; i++) begin
            model_cnt = (model_cnt + 4 > 255) ? 255 : model_cnt + 4;
            do_update((i % 2 == 0) ? 4'b1111 : 4'b0000, 8'(model_cnt));
        end
        check("sat_final", 32'(change_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
